// File: rtl/rv32i_types_pkg.sv
// Shared types for the load/store memory stage: queue entry, funct3 codes, FSM states, CDB payload.
package rv32i_types;

    localparam int unsigned rob_size = 5;
    localparam int unsigned xlen     = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } mem_f3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } ls_state_t;

    typedef struct packed {
        logic                valid;
        logic                mem_inst;
        logic                store;
        logic [2:0]          funct3;
        logic [xlen-1:0]     rs1_v;
        logic [xlen-1:0]     rs2_v;
        logic [xlen-1:0]     ls_imm;
        logic [rob_size-1:0] rob_id_dest;
    } ls_q_entry;

    typedef struct packed {
        logic                valid;
        logic [rob_size-1:0] rob_id;
        logic [xlen-1:0]     data;
        logic                exc;
    } cdb_t;

endpackage

// File: rtl/ls_mem_unit_align.sv
// Combinational address/alignment/mask/lane logic for the memory stage.
module ls_align
    import rv32i_types::*;
(
    input  logic [2:0]      funct3,
    input  logic [xlen-1:0] rs1_v,
    input  logic [xlen-1:0] ls_imm,
    input  logic [xlen-1:0] rs2_v,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic [xlen-1:0] rdata,
    output logic [xlen-1:0] aligned_addr,
    output logic [1:0]      offset,
    output logic            legal,
    output logic [3:0]      mask,
    output logic [xlen-1:0] wdata,
    output logic [xlen-1:0] ld_data
);

    logic [xlen-1:0] ea;
    logic [3:0]      base_mask;
    logic [xlen-1:0] ld_shifted;

    // Effective address, alignment check, byte mask and store lane shift
    always_comb begin
        ea           = rs1_v + ls_imm;
        offset       = ea[1:0];
        aligned_addr = {ea[xlen-1:2], 2'b00};
        legal        = 1'b0;
        base_mask    = 4'b1111;
        case (funct3)
            F3_B, F3_BU: legal = 1'b1;
            F3_H, F3_HU: legal = ~ea[0];
            F3_W:        legal = (ea[1:0] == 2'b00);
            default:     legal = 1'b0;
        endcase
        case (funct3[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        mask  = base_mask << offset;
        wdata = rs2_v << {offset, 3'b000};
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        ld_shifted = rdata >> {ld_offset, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_BU:   ld_data = {24'h0, ld_shifted[7:0]};
            F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_HU:   ld_data = {16'h0, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/ls_mem_unit.sv
// Single-outstanding data-memory stage between the load/store queue and the CDB.
module ls_mem_unit
    import rv32i_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  ls_q_entry           ls_in,
    output logic                in_flight_mem,
    output logic [xlen-1:0]     dmem_addr,
    output logic [3:0]          dmem_rmask,
    output logic [3:0]          dmem_wmask,
    output logic [xlen-1:0]     dmem_wdata,
    input  logic [xlen-1:0]     dmem_rdata,
    input  logic                dmem_resp,
    output logic                cdb_valid,
    output logic [rob_size-1:0] cdb_rob_id,
    output logic [xlen-1:0]     cdb_data,
    output logic                cdb_exc
);

    ls_state_t state, state_next;
    logic      accept;

    logic [xlen-1:0]     req_addr;
    logic [1:0]          req_off;
    logic [2:0]          req_f3;
    logic                req_store;
    logic [3:0]          req_rmask;
    logic [3:0]          req_wmask;
    logic [xlen-1:0]     req_wdata;
    logic [rob_size-1:0] rob_q;
    logic [xlen-1:0]     data_q;
    logic                exc_q;
    cdb_t                cdb_c;

    logic [xlen-1:0] a_addr;
    logic [1:0]      a_off;
    logic            a_legal;
    logic [3:0]      a_mask;
    logic [xlen-1:0] a_wdata;
    logic [xlen-1:0] a_ld_data;

    assign accept = (state == IDLE) && ls_in.valid && ls_in.mem_inst;

    ls_align u_align (
        .funct3       (ls_in.funct3),
        .rs1_v        (ls_in.rs1_v),
        .ls_imm       (ls_in.ls_imm),
        .rs2_v        (ls_in.rs2_v),
        .ld_funct3    (req_f3),
        .ld_offset    (req_off),
        .rdata        (dmem_rdata),
        .aligned_addr (a_addr),
        .offset       (a_off),
        .legal        (a_legal),
        .mask         (a_mask),
        .wdata        (a_wdata),
        .ld_data      (a_ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state: illegal accesses skip the memory request
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = a_legal ? REQ : DONE;
            REQ:     if (dmem_resp) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request payload captured at accept; load result captured on response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr  <= '0;
            req_off   <= '0;
            req_f3    <= '0;
            req_store <= 1'b0;
            req_rmask <= '0;
            req_wmask <= '0;
            req_wdata <= '0;
            rob_q     <= '0;
            data_q    <= '0;
            exc_q     <= 1'b0;
        end else if (accept) begin
            req_addr  <= a_addr;
            req_off   <= a_off;
            req_f3    <= ls_in.funct3;
            req_store <= ls_in.store;
            req_rmask <= ls_in.store ? 4'b0000 : a_mask;
            req_wmask <= ls_in.store ? a_mask : 4'b0000;
            req_wdata <= ls_in.store ? a_wdata : '0;
            rob_q     <= ls_in.rob_id_dest;
            data_q    <= '0;
            exc_q     <= ~a_legal;
        end else if ((state == REQ) && dmem_resp && !req_store) begin
            data_q <= a_ld_data;
        end
    end

    // Outputs are state decodes gating registered payloads
    always_comb begin
        in_flight_mem = (state != IDLE);
        dmem_addr     = '0;
        dmem_rmask    = '0;
        dmem_wmask    = '0;
        dmem_wdata    = '0;
        cdb_c         = '0;
        if (state == REQ) begin
            dmem_addr  = req_addr;
            dmem_rmask = req_rmask;
            dmem_wmask = req_wmask;
            dmem_wdata = req_wdata;
        end
        if (state == DONE) begin
            cdb_c.valid  = 1'b1;
            cdb_c.rob_id = rob_q;
            cdb_c.data   = data_q;
            cdb_c.exc    = exc_q;
        end
        cdb_valid  = cdb_c.valid;
        cdb_rob_id = cdb_c.rob_id;
        cdb_data   = cdb_c.data;
        cdb_exc    = cdb_c.exc;
    end

endmodule

// File: doc/ls_mem_unit.md
# ls_mem_unit

Single-outstanding data-memory stage sitting directly downstream of the load/store queue. It accepts one popped queue entry at a time, computes the effective address, drives a word-aligned request to data memory, and broadcasts the load result or store completion to the ROB/CDB. `in_flight_mem` is the backpressure signal the queue uses to decide whether it may pop.

## Interface
- `rob_size`, 5: width of a ROB id.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ls_in` in `ls_q_entry`: entry popped by the queue.
  - Accepted only when `ls_in.valid && ls_in.mem_inst`.
  - Fields used: `store`, `funct3`, `rs1_v`, `rs2_v`, `ls_imm`, `rob_id_dest`.
- `in_flight_mem` out 1: high whenever the state is not IDLE.
- `dmem_addr` out 32: word-aligned request address.
- `dmem_rmask` out 4: read byte mask.
- `dmem_wmask` out 4: write byte mask.
- `dmem_wdata` out 32: lane-aligned store data.
- `dmem_rdata` in 32: read data, valid when `dmem_resp` is high.
- `dmem_resp` in 1: single-cycle completion from memory.
- `cdb_valid` out 1: one-cycle completion broadcast.
- `cdb_rob_id` out `rob_size`: ROB id of the completing instruction.
- `cdb_data` out 32: extended load value; 0 for stores and exceptions.
- `cdb_exc` out 1: misaligned access or illegal funct3.

## Operation
- The FSM has three states: IDLE, REQ and DONE. On reset the state is IDLE and every output is 0.
- IDLE:
  - An accepted `ls_in` is registered.
  - `addr = rs1_v + ls_imm`, computed mod 2^32 with no overflow detection.
  - Alignment is legal for byte ops (funct3 000/100/ lb,lbu,sb) at any address.
  - Half ops (001/101) need `addr[0]==0`.
  - Word ops (010) need `addr[1:0]==0`.
  - Any other funct3 is illegal.
  - Illegal or misaligned accesses go to DONE with exc=1 and issue no memory request.
  - Legal accesses go to REQ.
- REQ:
  - `dmem_addr = {addr[31:2],2'b00}`.
  - Loads drive rmask: byte `4'b0001<<addr[1:0]`, half `4'b0011<<addr[1:0]`, word `4'b1111`. wmask is 0.
  - Stores drive wmask with the same encoding, rmask=0, and `dmem_wdata = rs2_v << (8*addr[1:0])`.
  - All request outputs are held stable until `dmem_resp` is sampled high.
  - On resp:
    - Loads capture `dmem_rdata >> (8*addr[1:0])`, then sign-extend (lb/lh) or zero-extend (lbu/lhu) from bit 7 or 15.
    - The unit goes to DONE.
    - The request outputs return to 0 on the next edge.
- DONE:
  - `cdb_valid=1` for exactly one cycle with `cdb_rob_id=rob_id_dest`, `cdb_data`, and `cdb_exc`.
  - The unit then returns to IDLE.
- `ls_in` arriving while not IDLE is ignored. The queue must never pop while `in_flight_mem` is high.
- `dmem_resp` arriving in IDLE or DONE is ignored.
- Reset asserted mid-operation: the request is dropped immediately and no broadcast is made.

## Timing
- Accept edge T, then REQ from T+1. `dmem_resp` may arrive as early as T+1.
- If resp is at cycle R, DONE (cdb_valid) is at R+1 and IDLE at R+2. The next accept is possible at R+2.
- Exception path: DONE at T+1, IDLE at T+2.
- `in_flight_mem` is a registered-state decode with no combinational path from `ls_in`. It is therefore low in the accept cycle and high from T+1 through the DONE cycle.
- All outputs are registered or pure state decodes, and none depend combinationally on `dmem_rdata`.
- Store completion also broadcasts, so the ROB can retire the store.

## Structure
- The shared package `rv32i_types` holds:
  - the `ls_q_entry` `store` bit (added);
  - the `mem_f3_t` funct3 enum;
  - the `ls_state_t` enum (IDLE/REQ/DONE);
  - a `cdb_t` struct {valid, rob_id, data, exc}.
- Sub-module `ls_align` (combinational) holds:
  - the alignment check;
  - mask generation;
  - store-data shift;
  - load shift and extend.
- The FSM, request registers and CDB register stay in `ls_mem_unit`.

## Test plan
- LW, rs1_v=0x1000, imm=4:
  - Required: dmem_addr=0x1004, rmask=1111.
  - With resp at T+3 carrying rdata=0xDEADBEEF: cdb_valid at T+4 with data=0xDEADBEEF and the correct rob_id.
  - in_flight_mem high T+1..T+4.
- LB at addr 0x2003, rdata=0x80FF_FFFF:
  - Required: rmask=1000, cdb_data=0xFFFFFF80.
  - The same case as LBU: cdb_data=0x00000080.
- SH at addr 0x3002, rs2_v=0x1234ABCD:
  - Required: dmem_addr=0x3000, wmask=1100, wdata=0xABCD0000.
  - Completion: cdb_valid with data=0, exc=0.
- LW at addr 0x4001:
  - Required: no mask is ever asserted, cdb_valid with exc=1 at T+1, back in IDLE at T+2.
  - funct3=011 behaves the same way.
- Back-to-back entries presented every cycle with resp after 1 cycle:
  - Required: only entries accepted in IDLE are processed.
  - Each entry produces exactly one broadcast, with no overlap and no dropped rob_id.
- Reset asserted while in REQ:
  - Required: masks and in_flight_mem go to 0 immediately, and no cdb_valid follows.
  - A dmem_resp arriving after reset has no effect.
